// File: rtl/c499_ecc_pkg.sv
// Shared widths, check-bit masks and parity helpers for the c499 SEC encoder.
// Group parities: con[j] = ^d[4j+3:4j]; str[j] / str[j+4] = strided nibbles from bit j / bit j+16.
package c499_ecc_pkg;

  localparam int DATA_W = 32;
  localparam int CHK_W  = 8;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [CHK_W-1:0]  chk_t;

  typedef struct packed {
    logic [7:0] str;
    logic [7:0] con;
  } grp_t;

  // One row per check bit: the data bits that check bit covers.
  localparam data_t CHK_MASK [0:CHK_W-1] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  function automatic grp_t grp_par(input data_t d);
    grp_t g;
    for (int j = 0; j < 8; j++) begin
      g.con[j] = ^d[4*j +: 4];
    end
    for (int j = 0; j < 4; j++) begin
      g.str[j]   = d[j]    ^ d[j+4]  ^ d[j+8]  ^ d[j+12];
      g.str[j+4] = d[j+16] ^ d[j+20] ^ d[j+24] ^ d[j+28];
    end
    return g;
  endfunction

  function automatic chk_t chk_from_grp(input grp_t g);
    chk_t c;
    c[0] = g.con[4] ^ g.con[5] ^ g.str[0];
    c[1] = g.con[6] ^ g.con[7] ^ g.str[1];
    c[2] = g.con[4] ^ g.con[6] ^ g.str[2];
    c[3] = g.con[5] ^ g.con[7] ^ g.str[3];
    c[4] = g.con[0] ^ g.con[1] ^ g.str[4];
    c[5] = g.con[2] ^ g.con[3] ^ g.str[5];
    c[6] = g.con[0] ^ g.con[2] ^ g.str[6];
    c[7] = g.con[1] ^ g.con[3] ^ g.str[7];
    return c;
  endfunction

  function automatic chk_t chk_from_data(input data_t d);
    chk_t c;
    for (int k = 0; k < CHK_W; k++) begin
      c[k] = ^(d & CHK_MASK[k]);
    end
    return c;
  endfunction

endpackage

// File: rtl/c499_enc_pipe_if.sv
// Word-in / codeword-out valid-ready bundle; slave is the encoder side, master the producer/consumer side.
interface c499_enc_pipe_if;
  import c499_ecc_pkg::*;

  logic  in_valid;
  data_t in_data;
  logic  in_ready;
  logic  out_valid;
  data_t out_data;
  chk_t  out_chk;
  logic  out_ready;

  modport slave (
    input  in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_chk
  );

  modport master (
    output in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_chk
  );

endinterface

// File: rtl/c499_chk_gen.sv
// Combinational reduction of the 16 group parities to the 8 check bits; zero latency, no handshake.
module c499_chk_gen
  import c499_ecc_pkg::*;
(
  input  grp_t grp,
  output chk_t chk
);

  assign chk = chk_from_grp(grp);

endmodule

// File: rtl/c499_enc_pipe.sv
// 2-stage SEC encoder, 2-cycle latency, full valid/ready back-pressure (in_ready combinational, no skid).
// C499_ERR_INJECT_EN adds a one-shot single-bit flip on the next stage-2 load.
module c499_enc_pipe
  import c499_ecc_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  c499_enc_pipe_if.slave   bus,
  output logic [CNT_W-1:0] word_cnt
`ifdef C499_ERR_INJECT_EN
  ,
  input  logic             inj_arm,
  input  logic [5:0]       inj_pos,
  output logic             inj_done
`endif
);

  logic  s1_valid;
  data_t s1_data;
  grp_t  s1_grp;
  logic  s2_valid;
  data_t s2_data;
  chk_t  s2_chk;

  logic  in_fire;
  logic  s1_adv;
  chk_t  chk_next;
  data_t ld_data;
  chk_t  ld_chk;

  assign bus.in_ready = !s1_valid || !s2_valid || bus.out_ready;
  assign in_fire      = bus.in_valid && bus.in_ready;
  assign s1_adv       = s1_valid && (!s2_valid || bus.out_ready);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_grp   <= '0;
    end else begin
      if (in_fire) begin
        s1_data <= bus.in_data;
        s1_grp  <= grp_par(bus.in_data);
      end
      s1_valid <= in_fire || (s1_valid && !s1_adv);
    end
  end

  c499_chk_gen u_chk_gen (
    .grp (s1_grp),
    .chk (chk_next)
  );

`ifdef C499_ERR_INJECT_EN
  logic       inj_armed;
  logic [5:0] inj_sel;

  assign inj_done = inj_armed && s1_adv;

  // Position is captured at arm time so the flip does not depend on inj_pos at load time.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      inj_armed <= 1'b0;
      inj_sel   <= '0;
    end else if (inj_arm) begin
      inj_armed <= 1'b1;
      inj_sel   <= inj_pos;
    end else if (inj_done) begin
      inj_armed <= 1'b0;
    end
  end

  always_comb begin
    ld_data = s1_data;
    ld_chk  = chk_next;
    if (inj_done) begin
      if (inj_sel < 6'd32) begin
        ld_data[inj_sel[4:0]] = ~s1_data[inj_sel[4:0]];
      end else if (inj_sel < 6'd40) begin
        ld_chk[inj_sel[2:0]] = ~chk_next[inj_sel[2:0]];
      end
    end
  end
`else
  assign ld_data = s1_data;
  assign ld_chk  = chk_next;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_chk   <= '0;
    end else begin
      if (s1_adv) begin
        s2_data <= ld_data;
        s2_chk  <= ld_chk;
      end
      s2_valid <= s1_adv || (s2_valid && !bus.out_ready);
    end
  end

  // The grouped reduction must agree with the flat mask form of the code.
  always_ff @(posedge clk) begin
    if (rst_n && s1_adv) begin
      assert (chk_next == chk_from_data(s1_data));
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      word_cnt <= '0;
    end else if (in_fire) begin
      word_cnt <= word_cnt + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.out_data  = s2_data;
  assign bus.out_chk   = s2_chk;

endmodule

// File: tb/tb_c499_enc_pipe.sv
// Directed/table bench for c499_enc_pipe with an independent mask-based encoder and corrector model.
module tb_c499_enc_pipe;

  logic clk = 1'b0;
  logic rst_n;
  logic [15:0] word_cnt;

  always #5 clk = ~clk;

  c499_enc_pipe_if bus ();

`ifdef C499_ERR_INJECT_EN
  logic       inj_arm;
  logic [5:0] inj_pos;
  logic       inj_done;
`endif

  c499_enc_pipe #(.CNT_W(16)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .bus      (bus),
    .word_cnt (word_cnt)
`ifdef C499_ERR_INJECT_EN
    ,
    .inj_arm  (inj_arm),
    .inj_pos  (inj_pos),
    .inj_done (inj_done)
`endif
  );

  localparam logic [31:0] M [0:7] = '{
    32'h00FF1111, 32'hFF002222, 32'h0F0F4444, 32'hF0F08888,
    32'h111100FF, 32'h2222FF00, 32'h44440F0F, 32'h8888F0F0
  };

  int errors = 0;
  int checks = 0;
  int acc_cnt = 0;
  logic prev_stall = 1'b0;
  logic [31:0] sb [$];

  typedef struct {
    logic [31:0] d;
    logic [7:0]  c;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] ref_chk(input logic [31:0] d);
    logic [7:0] c;
    for (int k = 0; k < 8; k++) c[k] = ^(d & M[k]);
    return c;
  endfunction

  function automatic logic [31:0] corr(input logic [31:0] d, input logic [7:0] c);
    logic [7:0]  syn;
    logic [7:0]  col;
    logic [31:0] r;
    r   = d;
    syn = c ^ ref_chk(d);
    for (int i = 0; i < 32; i++) begin
      for (int k = 0; k < 8; k++) col[k] = M[k][i];
      if (syn != 8'h00 && col == syn) r[i] = ~r[i];
    end
    return r;
  endfunction

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic iv, input logic [31:0] id, input logic ordy, output logic irdy);
    logic [31:0] exp;
    bus.in_valid  = iv;
    bus.in_data   = id;
    bus.out_ready = ordy;
    #1;
    irdy = bus.in_ready;
    if (prev_stall) check("stall_valid_held", bus.out_valid, 1);
    if (bus.out_valid && !ordy && sb.size() != 0)
      check("stall_data_head", {bus.out_data, bus.out_chk}, {sb[0], ref_chk(sb[0])});
    if (iv && irdy) begin
      sb.push_back(id);
      acc_cnt++;
    end
    if (bus.out_valid && ordy) begin
      if (sb.size() == 0) begin
        check("spurious_out_valid", bus.out_valid, 0);
      end else begin
        exp = sb.pop_front();
        check("out_data", bus.out_data, exp);
        check("out_chk", bus.out_chk, ref_chk(exp));
        check("corrector_out", corr(bus.out_data, bus.out_chk), exp);
      end
    end
    prev_stall = bus.out_valid && !ordy;
    @(negedge clk);
  endtask

  task automatic drain();
    logic irdy;
    for (int c = 0; c < 10 && sb.size() != 0; c++) step(1'b0, 32'h0, 1'b1, irdy);
    check("drain_empty", sb.size(), 0);
    #1 check("drain_out_valid", bus.out_valid, 0);
    @(negedge clk);
  endtask

  initial begin
    logic        irdy;
    logic [31:0] w;
    logic [31:0] seq;

    tbl[0] = '{d: 32'h00000000, c: 8'h00};
    tbl[1] = '{d: 32'h00000001, c: 8'h51};
    tbl[2] = '{d: 32'h00010000, c: 8'h15};
    tbl[3] = '{d: 32'hFFFFFFFF, c: 8'h00};
    tbl[4] = '{d: 32'h80000000, c: 8'h8A};
    tbl[5] = '{d: 32'h00000100, c: 8'h61};
    tbl[6] = '{d: 32'h0000000F, c: 8'h0F};
    tbl[7] = '{d: 32'hF0000000, c: 8'hF0};

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
`ifdef C499_ERR_INJECT_EN
    inj_arm = 1'b0;
    inj_pos = '0;
`endif
    @(negedge clk);
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_out_chk", bus.out_chk, 0);
    check("rst_word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    #1 check("rst_in_ready", bus.in_ready, 1);
    @(negedge clk);

    // Table: one word at a time, latency and check bits.
    for (int i = 0; i < 8; i++) begin
      bus.in_valid  = 1'b1;
      bus.in_data   = tbl[i].d;
      bus.out_ready = 1'b1;
      #1 check("tbl_in_ready", bus.in_ready, 1);
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 check("tbl_cycle1_valid", bus.out_valid, 0);
      @(negedge clk);
      #1;
      check("tbl_cycle2_valid", bus.out_valid, 1);
      check("tbl_data", bus.out_data, tbl[i].d);
      check("tbl_chk", bus.out_chk, tbl[i].c);
      @(negedge clk);
    end
    check("tbl_word_cnt", word_cnt, 8);

    // Random stream with random back-pressure through the corrector model.
    acc_cnt = 0;
    for (int cyc = 0; cyc < 5000 && acc_cnt < 1000; cyc++) begin
      w = $urandom;
      step(($urandom_range(0, 7) != 0), w, ($urandom_range(0, 3) != 0), irdy);
    end
    check("rand_accepted", acc_cnt, 1000);
    drain();

    // Stall: continuous input with out_ready low for 5 cycles.
    acc_cnt = 0;
    seq = 32'hA5A50000;
    for (int c = 0; c < 5; c++) begin
      step(1'b1, seq, 1'b0, irdy);
      if (irdy) seq = seq + 1;
    end
    check("stall_accepted", acc_cnt, 2);
    check("stall_in_ready", irdy, 0);
    step(1'b1, seq, 1'b1, irdy);
    check("full_shift_accept", irdy, 1);
    if (irdy) seq = seq + 1;
    for (int c = 0; c < 3; c++) begin
      step(1'b1, seq, 1'b1, irdy);
      if (irdy) seq = seq + 1;
    end
    drain();

    // Reset with two words in flight.
    step(1'b1, 32'h11111111, 1'b0, irdy);
    step(1'b1, 32'h22222222, 1'b0, irdy);
    rst_n        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_out_data", bus.out_data, 0);
    check("midrst_word_cnt", word_cnt, 0);
    rst_n = 1'b1;
    sb.delete();
    prev_stall = 1'b0;
    @(negedge clk);
    for (int c = 0; c < 3; c++) step(1'b0, 32'h0, 1'b1, irdy);
    check("midrst_no_output", bus.out_valid, 0);

    // Counter wrap after 0x10000 accepted words.
    bus.in_valid  = 1'b1;
    bus.in_data   = 32'h5A5A5A5A;
    bus.out_ready = 1'b1;
    repeat (65535) @(negedge clk);
    #1 check("cnt_ffff", word_cnt, 16'hFFFF);
    @(negedge clk);
    #1 check("cnt_wrap", word_cnt, 16'h0000);
    bus.in_valid = 1'b0;
    repeat (3) @(negedge clk);

`ifdef C499_ERR_INJECT_EN
    begin
      int pulses;
      pulses = 0;
      inj_arm = 1'b1;
      inj_pos = 6'd5;
      @(negedge clk);
      inj_arm       = 1'b0;
      bus.in_valid  = 1'b1;
      bus.in_data   = 32'h0;
      bus.out_ready = 1'b0;
      #1 if (inj_done) pulses++;
      @(negedge clk);
      bus.in_valid = 1'b0;
      #1 if (inj_done) pulses++;
      @(negedge clk);
      #1;
      check("inj_valid", bus.out_valid, 1);
      check("inj_data", bus.out_data, 32'h00000020);
      check("inj_chk", bus.out_chk, 8'h00);
      check("inj_corrected", corr(bus.out_data, bus.out_chk), 32'h0);
      for (int c = 0; c < 3; c++) begin
        if (inj_done) pulses++;
        @(negedge clk);
        #1;
      end
      check("inj_done_pulses", pulses, 1);
      @(negedge clk);
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      sb.delete();
      prev_stall = 1'b0;
      step(1'b1, 32'h0, 1'b1, irdy);
      drain();
    end
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
